// File: rtl/pe_mac_sequencer.sv
// Sequencer for one Eyeriss PE MultAdd datapath: walks the scratchpads per output pixel,
// accumulates FILT_LEN products, adds the vertical psum and hands the result downstream.
module pe_mac_sequencer #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned LEN_W  = 4,
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [LEN_W-1:0]  cfg_filt_len_i,
    input  logic [LEN_W-1:0]  cfg_ofmap_len_i,
    input  logic [LEN_W-1:0]  cfg_stride_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [ADDR_W-1:0] filt_raddr_o,
    output logic [ADDR_W-1:0] ifmap_raddr_o,
    output logic              spad_re_o,
    output logic              mac_en_o,
    output logic              mac_clear_o,
    output logic              mac_sel_b_o,
    input  logic [DATA_W-1:0] mac_data_out_i,
    input  logic              psum_in_valid_i,
    output logic              psum_in_ready_o,
    output logic              psum_out_valid_o,
    input  logic              psum_out_ready_i
);

    localparam logic [LEN_W-1:0] LenOne = LEN_W'(1);

    typedef enum logic [2:0] {
        StIdle, StClr, StMac, StDrain, StAddp, StWait, StOut, StDone
    } state_e;

    state_e state_q, state_d;

    logic [LEN_W-1:0]  j_q, j_d;
    logic [LEN_W-1:0]  k_q, k_d;
    logic [LEN_W-1:0]  filt_len_q, filt_len_d;
    logic [LEN_W-1:0]  ofmap_len_q, ofmap_len_d;
    logic [LEN_W-1:0]  stride_q, stride_d;
    // Running j*stride, so the ifmap address needs only an adder.
    logic [ADDR_W-1:0] base_q, base_d;

    logic              busy_q, done_q, spad_re_q, mac_en_q, mac_clear_q, mac_sel_b_q;
    logic              psum_in_ready_q, psum_out_valid_q;
    logic [ADDR_W-1:0] filt_raddr_q, ifmap_raddr_q;

    // The finished psum travels on the datapath bus; the sequencer never inspects it.
    logic unused_mac_data;
    assign unused_mac_data = ^mac_data_out_i;

    always_comb begin
        state_d     = state_q;
        j_d         = j_q;
        k_d         = k_q;
        base_d      = base_q;
        filt_len_d  = filt_len_q;
        ofmap_len_d = ofmap_len_q;
        stride_d    = stride_q;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    filt_len_d  = (cfg_filt_len_i == '0) ? LenOne : cfg_filt_len_i;
                    ofmap_len_d = (cfg_ofmap_len_i == '0) ? LenOne : cfg_ofmap_len_i;
                    stride_d    = cfg_stride_i;
                    j_d         = '0;
                    k_d         = '0;
                    base_d      = '0;
                    state_d     = StClr;
                end
            end
            StClr:   state_d = StMac;
            StMac: begin
                if (k_q == filt_len_q - LenOne) begin
                    state_d = StDrain;
                end else begin
                    k_d = k_q + LenOne;
                end
            end
            StDrain: state_d = StAddp;
            StAddp: begin
                if (psum_in_valid_i) begin
                    state_d = StWait;
                end
            end
            StWait:  state_d = StOut;
            StOut: begin
                if (psum_out_ready_i) begin
                    k_d = '0;
                    j_d = j_q + LenOne;
                    if (j_q < ofmap_len_q - LenOne) begin
                        base_d  = base_q + ADDR_W'(stride_q);
                        state_d = StClr;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs are registered from the next state so each is valid for the whole state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q          <= StIdle;
            j_q              <= '0;
            k_q              <= '0;
            base_q           <= '0;
            filt_len_q       <= '0;
            ofmap_len_q      <= '0;
            stride_q         <= '0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            spad_re_q        <= 1'b0;
            mac_en_q         <= 1'b0;
            mac_clear_q      <= 1'b0;
            mac_sel_b_q      <= 1'b0;
            psum_in_ready_q  <= 1'b0;
            psum_out_valid_q <= 1'b0;
            filt_raddr_q     <= '0;
            ifmap_raddr_q    <= '0;
        end else begin
            state_q          <= state_d;
            j_q              <= j_d;
            k_q              <= k_d;
            base_q           <= base_d;
            filt_len_q       <= filt_len_d;
            ofmap_len_q      <= ofmap_len_d;
            stride_q         <= stride_d;
            busy_q           <= (state_d != StIdle) && (state_d != StDone);
            done_q           <= (state_d == StDone);
            spad_re_q        <= (state_d == StMac);
            // Fire one cycle after each read to cover the scratchpad latency.
            mac_en_q         <= spad_re_q || (state_d == StAddp);
            mac_clear_q      <= (state_d == StClr);
            mac_sel_b_q      <= (state_d == StAddp);
            psum_in_ready_q  <= (state_d == StAddp);
            psum_out_valid_q <= (state_d == StOut);
            if (state_d == StMac) begin
                filt_raddr_q  <= ADDR_W'(k_d);
                ifmap_raddr_q <= base_d + ADDR_W'(k_d);
            end
        end
    end

    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign filt_raddr_o     = filt_raddr_q;
    assign ifmap_raddr_o    = ifmap_raddr_q;
    assign spad_re_o        = spad_re_q;
    assign mac_en_o         = mac_en_q;
    assign mac_clear_o      = mac_clear_q;
    assign mac_sel_b_o      = mac_sel_b_q;
    assign psum_in_ready_o  = psum_in_ready_q;
    assign psum_out_valid_o = psum_out_valid_q;

endmodule

// File: tb/tb_pe_mac_sequencer.sv
// Bench for pe_mac_sequencer: models scratchpads and MultAdd around the DUT and checks each
// pass against a sum-of-products reference computed straight from the convolution rules.
module tb_pe_mac_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  cfg_f = '0, cfg_o = '0, cfg_s = '0;
    logic        busy, done, spad_re, mac_en, mac_clear, mac_sel_b;
    logic [3:0]  filt_raddr, ifmap_raddr;
    logic [15:0] mac_data_out, psum_in_data;
    logic        psum_in_valid = 1'b0, psum_in_ready, psum_out_valid, psum_out_ready = 1'b0;
    logic [15:0] all_outs;

    pe_mac_sequencer #(.ADDR_W(4), .LEN_W(4), .DATA_W(16)) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .start_i          (start),
        .cfg_filt_len_i   (cfg_f),
        .cfg_ofmap_len_i  (cfg_o),
        .cfg_stride_i     (cfg_s),
        .busy_o           (busy),
        .done_o           (done),
        .filt_raddr_o     (filt_raddr),
        .ifmap_raddr_o    (ifmap_raddr),
        .spad_re_o        (spad_re),
        .mac_en_o         (mac_en),
        .mac_clear_o      (mac_clear),
        .mac_sel_b_o      (mac_sel_b),
        .mac_data_out_i   (mac_data_out),
        .psum_in_valid_i  (psum_in_valid),
        .psum_in_ready_o  (psum_in_ready),
        .psum_out_valid_o (psum_out_valid),
        .psum_out_ready_i (psum_out_ready)
    );

    always #5 clk = ~clk;

    assign all_outs = {busy, done, filt_raddr, ifmap_raddr, spad_re, mac_en, mac_clear,
                       mac_sel_b, psum_in_ready, psum_out_valid};

    // Environment: scratchpads with 1-cycle read latency and a MultAdd accumulator.
    logic [7:0]  filt_mem [16];
    logic [7:0]  ifmap_mem [16];
    logic [15:0] pin_vals [16];
    logic [7:0]  filt_rd = '0, ifmap_rd = '0;
    logic [15:0] acc = '0;
    int          hs_in_cnt = 0, pin_base = 0, cyc = 0;

    assign mac_data_out = acc;
    // Upstream psum gated to 0 while not valid, as the enclosing PE does.
    assign psum_in_data = psum_in_valid ? pin_vals[4'(hs_in_cnt - pin_base)] : 16'd0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (spad_re) begin
            filt_rd  <= filt_mem[filt_raddr];
            ifmap_rd <= ifmap_mem[ifmap_raddr];
        end
        if (mac_clear) acc <= '0;
        else if (mac_en) acc <= mac_sel_b ? acc + psum_in_data
                                          : acc + 16'(filt_rd) * 16'(ifmap_rd);
        if (psum_in_valid && psum_in_ready) hs_in_cnt <= hs_in_cnt + 1;
    end

    // Monitor: records reads, results and protocol violations.
    int          q_fa[$], q_ia[$], q_out[$], q_lat[$];
    int          clr_cyc = 0, done_cnt = 0, done_cyc = 0, last_hs_cyc = 0;
    int          viol_both = 0, viol_stable = 0, viol_busy = 0;
    logic        prev_wait = 1'b0;
    logic [15:0] prev_data = '0;

    always @(negedge clk) begin
        if (spad_re) begin
            q_fa.push_back(int'(filt_raddr));
            q_ia.push_back(int'(ifmap_raddr));
        end
        if (mac_clear) begin
            clr_cyc <= cyc;
            if (!busy) viol_busy <= viol_busy + 1;
        end
        if (psum_in_ready && psum_out_valid) viol_both <= viol_both + 1;
        if (prev_wait && (!psum_out_valid || mac_data_out != prev_data))
            viol_stable <= viol_stable + 1;
        prev_wait <= psum_out_valid && !psum_out_ready;
        prev_data <= mac_data_out;
        if (psum_out_valid && psum_out_ready) begin
            q_out.push_back(int'(mac_data_out));
            q_lat.push_back(cyc - clr_cyc + 1);
            last_hs_cyc <= cyc;
        end
        if (done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
            if (busy) viol_busy <= viol_busy + 1;
        end
    end

    // Handshake driver: hold valid/ready low for a programmable number of cycles.
    int in_gap = 0, out_gap = 0;

    initial begin : drv
        int ic, oc;
        ic = 0;
        oc = 0;
        forever begin
            @(posedge clk);
            #1;
            if (psum_in_ready) begin
                psum_in_valid = (ic >= in_gap);
                ic++;
            end else begin
                psum_in_valid = 1'($urandom_range(0, 1));
                ic = 0;
            end
            if (psum_out_valid) begin
                psum_out_ready = (oc >= out_gap);
                oc++;
            end else begin
                psum_out_ready = 1'($urandom_range(0, 1));
                oc = 0;
            end
        end
    end

    int n_checks = 0, n_fail = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic load_mems(input bit t1);
        for (int i = 0; i < 16; i++) begin
            filt_mem[i]  = t1 ? ((i < 3) ? 8'(i + 1) : 8'd0) : 8'($urandom_range(0, 255));
            ifmap_mem[i] = t1 ? ((i < 3) ? 8'(i + 4) : 8'd0) : 8'($urandom_range(0, 255));
            pin_vals[i]  = t1 ? 16'd10 : 16'($urandom_range(0, 65535));
        end
    endtask

    task automatic run_pass(input int f, input int o, input int s, input int ig, input int og,
                            input bit t6);
        int fe, oe, b_fa, b_out, d0, vb0, vs0, vu0, t, exp_sum, idx;
        fe = (f == 0) ? 1 : f;
        oe = (o == 0) ? 1 : o;
        in_gap   = ig;
        out_gap  = og;
        pin_base = hs_in_cnt;
        b_fa  = q_fa.size();
        b_out = q_out.size();
        d0    = done_cnt;
        vb0   = viol_both;
        vs0   = viol_stable;
        vu0   = viol_busy;
        @(posedge clk); #1;
        cfg_f = 4'(f); cfg_o = 4'(o); cfg_s = 4'(s); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        if (t6) begin
            cfg_f = 4'($urandom); cfg_o = 4'($urandom); cfg_s = 4'($urandom);
            repeat (2) @(posedge clk);
            #1 start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            cfg_f = 4'($urandom); cfg_o = 4'($urandom); cfg_s = 4'($urandom);
        end
        t = 0;
        while (done_cnt == d0 && t < 1500) begin
            @(posedge clk);
            t++;
        end
        repeat (3) @(posedge clk);
        #1;
        check_eq("done_pulses", done_cnt - d0, 1);
        check_eq("busy_after_done", int'(busy), 0);
        check_eq("done_after_last_hs", done_cyc - last_hs_cyc, 1);
        check_eq("n_outputs", q_out.size() - b_out, oe);
        for (int j = 0; j < oe; j++) begin
            exp_sum = int'(pin_vals[j]);
            for (int k = 0; k < fe; k++)
                exp_sum += int'(filt_mem[k]) * int'(ifmap_mem[(j * s + k) % 16]);
            exp_sum &= 32'hFFFF;
            if (b_out + j < q_out.size()) begin
                check_eq("psum_out", q_out[b_out + j], exp_sum);
                check_eq("latency", q_lat[b_out + j], fe + 5 + ig + og);
            end
        end
        check_eq("n_reads", q_fa.size() - b_fa, oe * fe);
        for (int j = 0; j < oe; j++) begin
            for (int k = 0; k < fe; k++) begin
                idx = b_fa + j * fe + k;
                if (idx < q_fa.size()) begin
                    check_eq("filt_raddr", q_fa[idx], k);
                    check_eq("ifmap_raddr", q_ia[idx], (j * s + k) % 16);
                end
            end
        end
        check_eq("in_ready_and_out_valid", viol_both - vb0, 0);
        check_eq("out_valid_stable", viol_stable - vs0, 0);
        check_eq("busy_protocol", viol_busy - vu0, 0);
    endtask

    initial begin : main
        int d0, t;
        load_mems(1'b0);
        #2;
        check_eq("reset_outputs", int'(all_outs), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // T1
        load_mems(1'b1);
        run_pass(3, 1, 1, 0, 0, 1'b0);
        check_eq("t1_psum", q_out[$], 42);
        check_eq("t1_latency", q_lat[$], 8);

        // T2
        load_mems(1'b0);
        run_pass(2, 3, 2, 0, 0, 1'b0);

        // T3: upstream psum late
        load_mems(1'b1);
        run_pass(3, 1, 1, 5, 0, 1'b0);
        check_eq("t3_psum", q_out[$], 42);

        // T4: downstream backpressure
        load_mems(1'b1);
        run_pass(3, 1, 1, 0, 4, 1'b0);
        check_eq("t4_psum", q_out[$], 42);
        check_eq("t4_latency", q_lat[$], 12);

        // T5: asynchronous reset mid-MAC
        load_mems(1'b1);
        in_gap  = 0;
        out_gap = 0;
        d0 = done_cnt;
        @(posedge clk); #1;
        cfg_f = 4'd3; cfg_o = 4'd1; cfg_s = 4'd1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        t = 0;
        while (!(spad_re && filt_raddr == 4'd1) && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        check_eq("t5_reached_k1", int'(filt_raddr), 1);
        #2 rst = 1'b1;
        #1;
        check_eq("t5_async_reset_outputs", int'(all_outs), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("t5_no_done", done_cnt - d0, 0);
        run_pass(3, 1, 1, 0, 0, 1'b0);
        check_eq("t5_rerun_psum", q_out[$], 42);

        // T6: start and cfg changes while busy
        load_mems(1'b0);
        run_pass(4, 3, 3, 1, 1, 1'b1);

        // Boundaries: single tap, zero lengths, address wrap
        load_mems(1'b0);
        run_pass(1, 2, 1, 0, 0, 1'b0);
        run_pass(0, 0, 1, 0, 0, 1'b0);
        run_pass(15, 2, 15, 0, 0, 1'b0);

        for (int r = 0; r < 16; r++) begin
            load_mems(1'b0);
            run_pass($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(1, 15),
                     $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
